// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, 1-cycle-latency imem, small instruction FIFO, redirect flush.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflightPc_q, inflightPc_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] instMem_q [FIFO_DEPTH];
    logic [31:0] pcMem_q   [FIFO_DEPTH];

    logic        active;
    logic        transfer;
    logic        respWrite;
    logic [CW:0] occupancy;

    assign active     = !reset && !redirect_valid;
    assign inst_valid = active && (count_q != '0);
    assign transfer   = inst_valid && inst_ready;
    assign respWrite  = inflight_q && !redirect_valid;

    // Counting the inflight response and this cycle's dequeue guarantees the response always has a slot.
    assign occupancy = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(transfer);
    assign imem_req  = active && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = pc_q;

    assign inst_out = instMem_q[rdPtr_q];
    assign pc_out   = pcMem_q[rdPtr_q];

    always_comb begin
        pc_d         = pc_q;
        inflight_d   = imem_req;
        inflightPc_d = pc_q;
        rdPtr_d      = rdPtr_q;
        wrPtr_d      = wrPtr_q;
        count_d      = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~32'h3;
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (imem_req) begin
                pc_d = pc_q + 32'd4;
            end
            if (transfer) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            if (respWrite) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            count_d = count_q + CW'(respWrite) - CW'(transfer);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= 32'h0;
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
            count_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (respWrite && !reset) begin
            instMem_q[wrPtr_q] <= imem_rdata;
            pcMem_q[wrPtr_q]   <= inflightPc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetched_q;
    logic [31:0] perfStall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perfFetched_q <= 32'h0;
            perfStall_q   <= 32'h0;
        end else begin
            if (transfer) begin
                perfFetched_q <= perfFetched_q + 32'd1;
            end
            if (inst_valid && !inst_ready) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perfFetched_q;
    assign perf_stall   = perfStall_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_stall   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences, and random traffic
// checked against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] K     = 32'hA5A5_0000;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_out(inst_out),
        .pc_out(pc_out),
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: every word is its own address xor K.
    always @(posedge clk) begin
        if (imem_req === 1'b1) begin
            imem_rdata <= imem_addr ^ K;
        end
    end

    typedef struct {
        logic        rst;
        logic        rdr;
        logic [31:0] rpc;
        logic        rdy;
        logic        eV;
        logic [31:0] ePc;
        logic        eR;
        logic [31:0] eA;
    } vec_t;

    vec_t vecs[$];

    // Reference model: buffered PCs in order, one pending response, next fetch PC.
    logic [31:0] mq[$];
    logic        mPend   = 1'b0;
    logic [31:0] mPendPc = 32'h0;
    logic [31:0] mPc     = 32'h0;
    logic [31:0] mFetched = 32'h0;
    logic [31:0] mStall   = 32'h0;

    task automatic checkVal(input string tag, input string field,
                            input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s %s actual=%h expected=%h", tag, field, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdr,
                                 input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        reset          = rst;
        redirect_valid = rdr;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic eV, input logic [31:0] ePc,
                               input logic eR, input logic [31:0] eA);
        checkVal(tag, "inst_valid", {31'h0, inst_valid}, {31'h0, eV});
        checkVal(tag, "imem_req", {31'h0, imem_req}, {31'h0, eR});
        if (eV) begin
            checkVal(tag, "pc_out", pc_out, ePc);
            checkVal(tag, "inst_out", inst_out, ePc ^ K);
        end
        if (eR) begin
            checkVal(tag, "imem_addr", imem_addr, eA);
        end
    endtask

    function automatic void modelPredict(input logic rst, input logic rdr, input logic rdy,
                                         output logic eV, output logic [31:0] ePc,
                                         output logic eR, output logic [31:0] eA);
        int deq;
        eV  = !rst && !rdr && (mq.size() > 0);
        ePc = eV ? mq[0] : 32'h0;
        deq = (eV && rdy) ? 1 : 0;
        eR  = !rst && !rdr && ((mq.size() + int'(mPend) - deq) < DEPTH);
        eA  = mPc;
    endfunction

    function automatic void modelEdge(input logic rst, input logic rdr,
                                      input logic [31:0] rpc, input logic rdy);
        logic eV, eR;
        logic [31:0] ePc, eA;
        modelPredict(rst, rdr, rdy, eV, ePc, eR, eA);
        if (rst) begin
            mq.delete();
            mPend = 1'b0;
            mPc = 32'h0;
            mFetched = 32'h0;
            mStall = 32'h0;
        end else if (rdr) begin
            mq.delete();
            mPend = 1'b0;
            mPc = {rpc[31:2], 2'b00};
        end else begin
            if (eV && rdy) begin
                void'(mq.pop_front());
                mFetched = mFetched + 32'd1;
            end
            if (eV && !rdy) mStall = mStall + 32'd1;
            if (mPend) mq.push_back(mPendPc);
            mPend = eR;
            mPendPc = mPc;
            if (eR) mPc = mPc + 32'd4;
        end
    endfunction

    task automatic runCycle(input string tag, input logic rst, input logic rdr,
                            input logic [31:0] rpc, input logic rdy);
        logic eV, eR;
        logic [31:0] ePc, eA;
        applyStimulus(rst, rdr, rpc, rdy);
        modelPredict(rst, rdr, rdy, eV, ePc, eR, eA);
        checkOutput(tag, eV, ePc, eR, eA);
        modelEdge(rst, rdr, rpc, rdy);
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b0;
        imem_rdata = 32'h0;

        // Streaming from reset with decode always ready.
        vecs.push_back('{1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h4});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h0, 1, 32'h8});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h4, 1, 32'hC});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h8, 1, 32'h10});
        // Backpressure from reset, then release.
        vecs.push_back('{1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h4});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h0, 1, 32'h8});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h0, 1, 32'hC});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h0, 1, 32'h10});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h4, 1, 32'h14});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h8, 1, 32'h18});
        // Redirect with 3 buffered entries and one fetch inflight.
        vecs.push_back('{1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h4});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h0, 1, 32'h8});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h0, 1, 32'hC});
        vecs.push_back('{0, 1, 32'h103, 0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h100});
        vecs.push_back('{0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h104});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h100, 1, 32'h108});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h100, 1, 32'h10C});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h104, 1, 32'h110});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h108, 1, 32'h114});
        // PC wrap through the top of the address space.
        vecs.push_back('{0, 1, 32'hFFFF_FFF8, 1, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 0, 32'h0, 1, 32'hFFFF_FFF8});
        vecs.push_back('{0, 0, 32'h0, 1, 0, 32'h0, 1, 32'hFFFF_FFFC});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'hFFFF_FFF8, 1, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 1, 32'h4});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h0, 1, 32'h8});
        // Fill the FIFO at 0x200, then reset mid-operation.
        vecs.push_back('{1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 1, 32'h200, 0, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h200});
        vecs.push_back('{0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h204});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h200, 1, 32'h208});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h200, 1, 32'h20C});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h200, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h200, 0, 32'h0});
        vecs.push_back('{1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h4});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h0, 1, 32'h8});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h4, 1, 32'hC});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].rdr, vecs[i].rpc, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].eV, vecs[i].ePc, vecs[i].eR, vecs[i].eA);
            modelEdge(vecs[i].rst, vecs[i].rdr, vecs[i].rpc, vecs[i].rdy);
        end

        // Perf counters: 10 transfers followed by 5 stalled cycles.
        runCycle("perf", 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 12; i++) runCycle("perf", 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) runCycle("perf", 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
`ifdef FETCH_PERF_CNT_EN
        checkVal("perf", "perf_fetched", perf_fetched, 32'd10);
        checkVal("perf", "perf_stall", perf_stall, 32'd5);
`else
        checkVal("perf", "perf_fetched", perf_fetched, 32'd0);
        checkVal("perf", "perf_stall", perf_stall, 32'd0);
`endif

        // Random traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            logic rst, rdr, rdy;
            logic [31:0] rpc;
            rst = (i == 0) || ($urandom_range(0, 59) == 0);
            rdr = ($urandom_range(0, 11) == 0);
            rpc = $urandom;
            rdy = ($urandom_range(0, 2) != 0);
            runCycle($sformatf("rand%0d", i), rst, rdr, rpc, rdy);
        end
        @(posedge clk);
        #1;
`ifdef FETCH_PERF_CNT_EN
        checkVal("rand", "perf_fetched", perf_fetched, mFetched);
        checkVal("rand", "perf_stall", perf_stall, mStall);
`else
        checkVal("rand", "perf_fetched", perf_fetched, 32'd0);
        checkVal("rand", "perf_stall", perf_stall, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
